// File: rtl/wb_complex_sequencer.sv
// Writeback stage: integer RF data select plus a two-state serializer for dual complex RF writes.
// Optional stall counter port enabled by defining WB_STALL_CNT_EN.
module wb_complex_sequencer #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned RADDR_W = 5,
    parameter int unsigned CADDR_W = 4,
    parameter int unsigned CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst_b,
    input  logic               mem_to_reg_i,
    input  logic               reg_write_en_i,
    input  logic               jal_i,
    input  logic [RADDR_W-1:0] write_register_i,
    input  logic [DATA_W-1:0]  cache_data_out_i,
    input  logic [DATA_W-1:0]  alu_result_i,
    input  logic [DATA_W-1:0]  pc_i,
    input  logic               reg_write_en_c_i,
    input  logic [CADDR_W-1:0] complex_write_register_i,
    input  logic [CADDR_W-1:0] complex_write_register2_i,
    input  logic [DATA_W-1:0]  mem_data1_out_c_i,
    input  logic [DATA_W-1:0]  mem_data2_out_c_i,
    input  logic               mem_to_reg_c_i,
    input  logic [DATA_W-1:0]  alu_result2_i,
    input  logic               input_format_c_i,
    output logic               rf_we_o,
    output logic [RADDR_W-1:0] rf_waddr_o,
    output logic [DATA_W-1:0]  rf_wdata_o,
    output logic               crf_we_o,
    output logic [CADDR_W-1:0] crf_waddr_o,
    output logic [DATA_W-1:0]  crf_wdata_o,
    output logic               wb_stall_o
`ifdef WB_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]   stall_cnt_o
`endif
);

    typedef enum logic {StFirst, StSecond} state_e;

    state_e state_q, state_d;

    logic              pack;
    logic [DATA_W-1:0] m1, m2, v1, v2;
    logic              crf_we, stall;
    logic [CADDR_W-1:0] crf_waddr;
    logic [DATA_W-1:0]  crf_wdata;

    always_comb begin
        pack = input_format_c_i & mem_to_reg_c_i;
        if (pack) begin
            m1 = {{(DATA_W-16){mem_data1_out_c_i[31]}}, mem_data1_out_c_i[31:16]};
            m2 = {{(DATA_W-16){mem_data1_out_c_i[15]}}, mem_data1_out_c_i[15:0]};
        end else begin
            m1 = mem_data1_out_c_i;
            m2 = mem_data2_out_c_i;
        end
        v1 = mem_to_reg_c_i ? m1 : alu_result_i;
        v2 = mem_to_reg_c_i ? m2 : alu_result2_i;
    end

    always_comb begin
        crf_we    = 1'b0;
        crf_waddr = complex_write_register_i;
        crf_wdata = v1;
        stall     = 1'b0;
        state_d   = state_q;
        unique case (state_q)
            StFirst: begin
                if (reg_write_en_c_i) begin
                    crf_we = 1'b1;
                    if (complex_write_register_i != complex_write_register2_i) begin
                        stall   = 1'b1;
                        state_d = StSecond;
                    end else begin
                        // Same destination: only the second value would survive.
                        crf_waddr = complex_write_register2_i;
                        crf_wdata = v2;
                    end
                end
            end
            StSecond: begin
                crf_we    = 1'b1;
                crf_waddr = complex_write_register2_i;
                crf_wdata = v2;
                state_d   = StFirst;
            end
            default: state_d = StFirst;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= StFirst;
        end else begin
            state_q <= state_d;
        end
    end

    // Enables are gated by reset so nothing writes while rst_b is held low.
    always_comb begin
        rf_we_o     = rst_b & reg_write_en_i & (write_register_i != '0) & (state_q == StFirst);
        rf_waddr_o  = write_register_i;
        rf_wdata_o  = jal_i ? (pc_i + DATA_W'(4)) : (mem_to_reg_i ? cache_data_out_i : alu_result_i);
        crf_we_o    = rst_b & crf_we;
        crf_waddr_o = crf_waddr;
        crf_wdata_o = crf_wdata;
        wb_stall_o  = rst_b & stall;
    end

`ifdef WB_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_wb_complex_sequencer.sv
// Directed plus randomized bench for wb_complex_sequencer against a transaction-level model.
module tb_wb_complex_sequencer;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        mem_to_reg, reg_write_en, jal;
    logic [4:0]  write_register;
    logic [31:0] cache_data_out, alu_result, pc;
    logic        reg_write_en_c;
    logic [3:0]  cdest1, cdest2;
    logic [31:0] md1, md2, alu_result2;
    logic        mem_to_reg_c, input_format_c;
    logic        rf_we, crf_we, wb_stall;
    logic [4:0]  rf_waddr;
    logic [3:0]  crf_waddr;
    logic [31:0] rf_wdata, crf_wdata;
`ifdef WB_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int sc_model = 0;

    always #5 clk = ~clk;

    wb_complex_sequencer dut (
        .clk                       (clk),
        .rst_b                     (rst_b),
        .mem_to_reg_i              (mem_to_reg),
        .reg_write_en_i            (reg_write_en),
        .jal_i                     (jal),
        .write_register_i          (write_register),
        .cache_data_out_i          (cache_data_out),
        .alu_result_i              (alu_result),
        .pc_i                      (pc),
        .reg_write_en_c_i          (reg_write_en_c),
        .complex_write_register_i  (cdest1),
        .complex_write_register2_i (cdest2),
        .mem_data1_out_c_i         (md1),
        .mem_data2_out_c_i         (md2),
        .mem_to_reg_c_i            (mem_to_reg_c),
        .alu_result2_i             (alu_result2),
        .input_format_c_i          (input_format_c),
        .rf_we_o                   (rf_we),
        .rf_waddr_o                (rf_waddr),
        .rf_wdata_o                (rf_wdata),
        .crf_we_o                  (crf_we),
        .crf_waddr_o               (crf_waddr),
        .crf_wdata_o               (crf_wdata),
        .wb_stall_o                (wb_stall)
`ifdef WB_STALL_CNT_EN
        ,
        .stall_cnt_o               (stall_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sext16(input logic [31:0] h);
        int v;
        v = int'(h & 32'hFFFF);
        if (v >= 32768) v -= 65536;
        return 32'(v);
    endfunction

    task automatic clear_inputs();
        mem_to_reg = 0; reg_write_en = 0; jal = 0; write_register = 0;
        cache_data_out = 0; alu_result = 0; pc = 0; reg_write_en_c = 0;
        cdest1 = 0; cdest2 = 0; md1 = 0; md2 = 0; mem_to_reg_c = 0;
        alu_result2 = 0; input_format_c = 0;
    endtask

    // Called at posedge+1 with inputs applied; returns aligned at posedge+1.
    task automatic run_op(input string tag);
        logic [31:0] exp_rd, m1, m2, v1, v2;
        logic        exp_rwe, dual, single;
        exp_rwe = reg_write_en && (write_register != 0);
        exp_rd  = jal ? pc + 32'd4 : (mem_to_reg ? cache_data_out : alu_result);
        if (input_format_c && mem_to_reg_c) begin
            m1 = sext16(md1 >> 16);
            m2 = sext16(md1);
        end else begin
            m1 = md1;
            m2 = md2;
        end
        v1 = mem_to_reg_c ? m1 : alu_result;
        v2 = mem_to_reg_c ? m2 : alu_result2;
        dual   = reg_write_en_c && (cdest1 != cdest2);
        single = reg_write_en_c && (cdest1 == cdest2);

        @(negedge clk);
        chk({tag, ".rf_we"}, 32'(rf_we), 32'(exp_rwe));
        chk({tag, ".rf_wdata"}, rf_wdata, exp_rd);
        if (exp_rwe) chk({tag, ".rf_waddr"}, 32'(rf_waddr), 32'(write_register));
        chk({tag, ".crf_we0"}, 32'(crf_we), 32'(dual || single));
        chk({tag, ".stall0"}, 32'(wb_stall), 32'(dual));
        if (dual) begin
            chk({tag, ".crf_waddr0"}, 32'(crf_waddr), 32'(cdest1));
            chk({tag, ".crf_wdata0"}, crf_wdata, v1);
        end else if (single) begin
            chk({tag, ".crf_waddr0"}, 32'(crf_waddr), 32'(cdest2));
            chk({tag, ".crf_wdata0"}, crf_wdata, v2);
        end
        @(posedge clk); #1;
        if (dual) begin
            sc_model++;
            @(negedge clk);
            chk({tag, ".rf_we1"}, 32'(rf_we), 32'd0);
            chk({tag, ".crf_we1"}, 32'(crf_we), 32'd1);
            chk({tag, ".crf_waddr1"}, 32'(crf_waddr), 32'(cdest2));
            chk({tag, ".crf_wdata1"}, crf_wdata, v2);
            chk({tag, ".stall1"}, 32'(wb_stall), 32'd0);
            @(posedge clk); #1;
        end
`ifdef WB_STALL_CNT_EN
        chk({tag, ".stall_cnt"}, stall_cnt, 32'(sc_model));
`endif
    endtask

    initial begin
        clear_inputs();
        reg_write_en = 1; write_register = 5; reg_write_en_c = 1; cdest1 = 1; cdest2 = 2;
        rst_b = 0;
        #2;
        chk("reset.rf_we", 32'(rf_we), 32'd0);
        chk("reset.crf_we", 32'(crf_we), 32'd0);
        chk("reset.stall", 32'(wb_stall), 32'd0);
`ifdef WB_STALL_CNT_EN
        chk("reset.stall_cnt", stall_cnt, 32'd0);
`endif
        clear_inputs();
        @(negedge clk); rst_b = 1;
        @(posedge clk); #1;

        alu_result = 32'h1234; reg_write_en = 1; write_register = 5;
        run_op("t1");

        clear_inputs();
        jal = 1; reg_write_en = 1; pc = 32'h0040_0010; write_register = 31; mem_to_reg = 1;
        run_op("t2a");
        write_register = 0;
        run_op("t2b");

        clear_inputs();
        reg_write_en_c = 1; cdest1 = 2; cdest2 = 3; mem_to_reg_c = 1;
        md1 = 32'hAAAA_0001; md2 = 32'h5555_0002; reg_write_en = 1; write_register = 9;
        run_op("t3");

        input_format_c = 1; md1 = 32'hFFFE_0003;
        run_op("t4");

        cdest1 = 7; cdest2 = 7; input_format_c = 0; mem_to_reg_c = 0;
        alu_result = 32'h1111; alu_result2 = 32'h2222;
        run_op("t5");

        // Reset pulled low while the second write is pending.
        clear_inputs();
        reg_write_en_c = 1; cdest1 = 4; cdest2 = 5; alu_result = 32'hA; alu_result2 = 32'hB;
        @(negedge clk);
        chk("t6.stall0", 32'(wb_stall), 32'd1);
        @(posedge clk); #1;
        sc_model++;
        chk("t6.second_we", 32'(crf_we), 32'd1);
        rst_b = 0; #1;
        sc_model = 0;
        chk("t6.rst_crf_we", 32'(crf_we), 32'd0);
        chk("t6.rst_stall", 32'(wb_stall), 32'd0);
`ifdef WB_STALL_CNT_EN
        chk("t6.rst_stall_cnt", stall_cnt, 32'd0);
`endif
        reg_write_en_c = 0;
        @(negedge clk); rst_b = 1;
        @(negedge clk);
        chk("t6.after_crf_we", 32'(crf_we), 32'd0);
        chk("t6.after_stall", 32'(wb_stall), 32'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 3; i++) begin
            clear_inputs();
            reg_write_en_c = 1; cdest1 = 4'(i); cdest2 = 4'(i + 8); alu_result = 32'(i);
            run_op($sformatf("t6.dual%0d", i));
        end

        for (int i = 0; i < 60; i++) begin
            mem_to_reg     = 1'($urandom);
            reg_write_en   = 1'($urandom);
            jal            = ($urandom_range(0, 3) == 0);
            write_register = 5'($urandom_range(0, 3) == 0 ? 0 : $urandom);
            cache_data_out = $urandom;
            alu_result     = $urandom;
            pc             = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
            reg_write_en_c = 1'($urandom);
            cdest1         = 4'($urandom);
            cdest2         = ($urandom_range(0, 3) == 0) ? cdest1 : 4'($urandom);
            md1            = $urandom;
            md2            = $urandom;
            mem_to_reg_c   = 1'($urandom);
            alu_result2    = $urandom;
            input_format_c = 1'($urandom);
            run_op($sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
